// File: rtl/aibcr3_dll_tap_ctrl.sv
//------------------------------------------------------------------------------
// aibcr3_dll_tap_ctrl : AIB DLL loop controller (vote filter, 6-bit code,
// 64-bit thermometer tap enables, lock tracking). Optional manual override
// is compiled in with AIBCR3_DLL_OVRD_EN.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module aibcr3_dll_tap_ctrl #(
  parameter logic [5:0] INIT_CODE = 6'd32,
  parameter int         FILT_TH   = 4,
  parameter int         LOCK_CNT  = 3
) (
  input  logic        CLKIN,
  input  logic        RST,
  input  logic        dll_en,
  input  logic        pd_valid,
  input  logic        pd_up,
  input  logic        pd_dn,
  input  logic        ovrd_en,
  input  logic [5:0]  ovrd_code,
  output logic [63:0] bk,
  output logic [5:0]  dly_code,
  output logic        dll_lock,
  output logic        sat_hi,
  output logic        sat_lo
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic signed [3:0] TH_POS   = 4'(FILT_TH);
  localparam logic signed [3:0] TH_NEG   = -TH_POS;
  localparam logic        [2:0] LOCK_TGT = 3'(LOCK_CNT);

  function automatic logic [63:0] therm(input logic [5:0] c);
    return ~(64'hFFFF_FFFF_FFFF_FFFE << c);
  endfunction

  state_t            state_q, state_d;
  logic [5:0]        code_q, code_d;
  logic [63:0]       bk_q;
  logic signed [3:0] acc_q, acc_d, acc_inc;
  logic [2:0]        rev_q, rev_d;
  logic              dir_q, dir_d;     // last step direction, 1 = up
  logic              first_q, first_d; // next step only records direction
  logic              same_q, same_d;   // one same-direction step seen while locked
  logic              sat_hi_q, sat_hi_d, sat_lo_q, sat_lo_d;
  logic              vote_up, vote_dn, step_up, step_dn, step_sat;

  always_comb begin
    vote_up  = dll_en & pd_valid & pd_up & ~pd_dn & (state_q != ST_IDLE);
    vote_dn  = dll_en & pd_valid & pd_dn & ~pd_up & (state_q != ST_IDLE);
    acc_inc  = acc_q;
    if (vote_up)      acc_inc = acc_q + 4'sd1;
    else if (vote_dn) acc_inc = acc_q - 4'sd1;
    step_up  = vote_up & (acc_inc == TH_POS);
    step_dn  = vote_dn & (acc_inc == TH_NEG);
    step_sat = (step_up & (code_q == 6'd63)) | (step_dn & (code_q == 6'd0));

    state_d  = state_q;
    code_d   = code_q;
    acc_d    = (step_up | step_dn) ? 4'sd0 : acc_inc;
    rev_d    = rev_q;
    dir_d    = dir_q;
    first_d  = first_q;
    same_d   = same_q;
    sat_hi_d = sat_hi_q;
    sat_lo_d = sat_lo_q;

    case (state_q)
      ST_IDLE: begin
        acc_d    = '0;
        rev_d    = '0;
        first_d  = 1'b1;
        same_d   = 1'b0;
        sat_hi_d = 1'b0;
        sat_lo_d = 1'b0;
        if (dll_en) state_d = ST_SEARCH;
      end
      default: begin
        if (step_up) sat_lo_d = 1'b0;
        if (step_dn) sat_hi_d = 1'b0;
        if (step_sat) begin
          if (step_up) sat_hi_d = 1'b1;
          else         sat_lo_d = 1'b1;
          if (state_q == ST_LOCKED) begin
            state_d = ST_SEARCH;
            rev_d   = '0;
            same_d  = 1'b0;
          end
        end else if (step_up | step_dn) begin
          code_d = step_up ? code_q + 6'd1 : code_q - 6'd1;
          dir_d  = step_up;
          if (first_q) begin
            first_d = 1'b0;
          end else if (step_up != dir_q) begin
            rev_d  = (rev_q == 3'd7) ? rev_q : rev_q + 3'd1;
            same_d = 1'b0;
            if ((state_q == ST_SEARCH) && (rev_d == LOCK_TGT)) state_d = ST_LOCKED;
          end else begin
            rev_d = '0;
            if (state_q == ST_LOCKED) begin
              if (same_q) begin
                state_d = ST_SEARCH;
                same_d  = 1'b0;
              end else begin
                same_d = 1'b1;
              end
            end
          end
        end
      end
    endcase

    if (!dll_en) begin
      state_d  = ST_IDLE;
      acc_d    = '0;
      rev_d    = '0;
      first_d  = 1'b1;
      same_d   = 1'b0;
      sat_hi_d = 1'b0;
      sat_lo_d = 1'b0;
    end

`ifdef AIBCR3_DLL_OVRD_EN
    if (ovrd_en) begin
      state_d  = ST_IDLE;
      code_d   = ovrd_code;
      acc_d    = '0;
      rev_d    = '0;
      first_d  = 1'b1;
      same_d   = 1'b0;
      sat_hi_d = 1'b0;
      sat_lo_d = 1'b0;
    end
`endif
  end

`ifndef AIBCR3_DLL_OVRD_EN
  logic unused_ovrd;
  assign unused_ovrd = ^{ovrd_en, ovrd_code};
`endif

  // bk is loaded from the next code so it can never lag dly_code
  always_ff @(posedge CLKIN or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      code_q   <= INIT_CODE;
      bk_q     <= therm(INIT_CODE);
      acc_q    <= '0;
      rev_q    <= '0;
      dir_q    <= 1'b0;
      first_q  <= 1'b1;
      same_q   <= 1'b0;
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      bk_q     <= therm(code_d);
      acc_q    <= acc_d;
      rev_q    <= rev_d;
      dir_q    <= dir_d;
      first_q  <= first_d;
      same_q   <= same_d;
      sat_hi_q <= sat_hi_d;
      sat_lo_q <= sat_lo_d;
    end
  end

  assign bk       = bk_q;
  assign dly_code = code_q;
  assign dll_lock = (state_q == ST_LOCKED);
  assign sat_hi   = sat_hi_q;
  assign sat_lo   = sat_lo_q;

endmodule

`default_nettype wire

// File: tb/tb_aibcr3_dll_tap_ctrl.sv
// Self-checking bench for aibcr3_dll_tap_ctrl: directed scenarios plus a
// randomized run against a behavioural loop model.
`default_nettype none

module tb_aibcr3_dll_tap_ctrl;

  localparam int INIT_CODE = 32;
  localparam int FILT_TH   = 4;
  localparam int LOCK_CNT  = 3;
`ifdef AIBCR3_DLL_OVRD_EN
  localparam bit OVRD_ON = 1'b1;
`else
  localparam bit OVRD_ON = 1'b0;
`endif

  logic        CLKIN, RST, dll_en, pd_valid, pd_up, pd_dn, ovrd_en;
  logic [5:0]  ovrd_code;
  logic [63:0] bk;
  logic [5:0]  dly_code;
  logic        dll_lock, sat_hi, sat_lo;

  int n_checks = 0;
  int n_errors = 0;

  aibcr3_dll_tap_ctrl #(
    .INIT_CODE (6'(INIT_CODE)),
    .FILT_TH   (FILT_TH),
    .LOCK_CNT  (LOCK_CNT)
  ) dut (
    .CLKIN     (CLKIN),
    .RST       (RST),
    .dll_en    (dll_en),
    .pd_valid  (pd_valid),
    .pd_up     (pd_up),
    .pd_dn     (pd_dn),
    .ovrd_en   (ovrd_en),
    .ovrd_code (ovrd_code),
    .bk        (bk),
    .dly_code  (dly_code),
    .dll_lock  (dll_lock),
    .sat_hi    (sat_hi),
    .sat_lo    (sat_lo)
  );

  initial CLKIN = 1'b0;
  always #5 CLKIN = ~CLKIN;

  // ---------------- behavioural reference model ----------------
  localparam int M_IDLE = 0, M_SEARCH = 1, M_LOCKED = 2;
  int m_code, m_acc, m_rev, m_mode, m_dir, m_same;
  bit m_fresh, m_shi, m_slo;

  function automatic logic [63:0] therm_ref(input int c);
    logic [63:0] t;
    for (int k = 0; k < 64; k++) t[k] = (k <= c);
    return t;
  endfunction

  function automatic void m_clear_idle();
    m_mode = M_IDLE; m_acc = 0; m_rev = 0; m_same = 0;
    m_fresh = 1'b1; m_shi = 1'b0; m_slo = 1'b0;
  endfunction

  function automatic void m_reset();
    m_code = INIT_CODE; m_dir = 0;
    m_clear_idle();
  endfunction

  function automatic void m_step(input int d);
    if (d > 0) m_slo = 1'b0; else m_shi = 1'b0;
    if (m_code + d > 63 || m_code + d < 0) begin
      if (d > 0) m_shi = 1'b1; else m_slo = 1'b1;
      if (m_mode == M_LOCKED) begin m_mode = M_SEARCH; m_rev = 0; m_same = 0; end
      return;
    end
    m_code += d;
    if (m_fresh) begin m_fresh = 1'b0; m_dir = d; return; end
    if (d != m_dir) begin
      m_rev  = (m_rev < 7) ? m_rev + 1 : 7;
      m_same = 0;
    end else begin
      m_rev = 0;
      if (m_mode == M_LOCKED) m_same++;
    end
    m_dir = d;
    if (m_mode == M_LOCKED && m_same >= 2) begin
      m_mode = M_SEARCH; m_rev = 0; m_same = 0;
    end else if (m_mode == M_SEARCH && m_rev == LOCK_CNT) begin
      m_mode = M_LOCKED; m_same = 0;
    end
  endfunction

  function automatic void m_tick(input bit en, input bit v, input bit up, input bit dn,
                                 input bit oe, input logic [5:0] oc);
    if (OVRD_ON && oe) begin m_clear_idle(); m_code = int'(oc); return; end
    if (!en) begin m_clear_idle(); return; end
    if (m_mode == M_IDLE) begin m_mode = M_SEARCH; return; end
    if (v && (up != dn)) begin
      m_acc += up ? 1 : -1;
      if (m_acc == FILT_TH)       begin m_acc = 0; m_step(1);  end
      else if (m_acc == -FILT_TH) begin m_acc = 0; m_step(-1); end
    end
  endfunction

  // ---------------- stimulus primitives ----------------
  task automatic cyc(input bit en, input bit v, input bit up, input bit dn);
    dll_en = en; pd_valid = v; pd_up = up; pd_dn = dn;
    @(posedge CLKIN);
    m_tick(en, v, up, dn, ovrd_en, ovrd_code);
    #1;
  endtask

  task automatic votes(input bit up, input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, up, !up);
  endtask

  task automatic restart();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RST = 1'b1; dll_en = 1'b0; pd_valid = 1'b0; pd_up = 1'b0; pd_dn = 1'b0;
    ovrd_en = 1'b0; ovrd_code = 6'd0;
    repeat (3) @(posedge CLKIN);
    #1;
    n_checks++;
    if (dly_code !== 6'd32) begin n_errors++; $display("FAIL reset_code: got %0d want 32", dly_code); end
    n_checks++;
    if (bk !== 64'h0000_0001_FFFF_FFFF) begin n_errors++; $display("FAIL reset_bk: got %h want 00000001ffffffff", bk); end
    n_checks++;
    if ({dll_lock, sat_hi, sat_lo} !== 3'b000) begin
      n_errors++; $display("FAIL reset_flags: got lock/hi/lo %b want 000", {dll_lock, sat_hi, sat_lo});
    end
    RST = 1'b0;
    m_reset();
  endtask

  task automatic test_step();
    int base, expc;
    restart();
    base = m_code;
    for (int i = 0; i < 4; i++) begin
      votes(1'b1, 1);
      expc = (i < 3) ? base : base + 1;
      n_checks++;
      if (dly_code !== 6'(expc) || bk !== therm_ref(expc)) begin
        n_errors++; $display("FAIL step_vote%0d: got code %0d bk %h want code %0d bk %h", i, dly_code, bk, expc, therm_ref(expc));
      end
    end
    for (int i = 0; i < 4; i++) begin
      votes(i[0] == 1'b0, 1);
      n_checks++;
      if (dly_code !== 6'(base + 1)) begin
        n_errors++; $display("FAIL no_step%0d: got %0d want %0d", i, dly_code, base + 1);
      end
    end
  endtask

  task automatic test_lock();
    int base;
    bit dirs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int offs[6] = '{1, 0, 1, 0, -1, -2};
    bit lk_pre[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bit lk_post[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    restart();
    base = m_code;
    for (int g = 0; g < 6; g++) begin
      votes(dirs[g], 3);
      n_checks++;
      if (dll_lock !== lk_pre[g]) begin
        n_errors++; $display("FAIL lock_pre_g%0d: got %b want %b", g, dll_lock, lk_pre[g]);
      end
      votes(dirs[g], 1);
      n_checks++;
      if (dll_lock !== lk_post[g] || dly_code !== 6'(base + offs[g])) begin
        n_errors++; $display("FAIL lock_post_g%0d: got lock %b code %0d want lock %b code %0d",
                             g, dll_lock, dly_code, lk_post[g], base + offs[g]);
      end
    end
  endtask

  task automatic test_async_reset();
    restart();
    votes(1'b1, 4);
    @(negedge CLKIN);
    #2;
    RST = 1'b1;
    #1;
    n_checks++;
    if (dly_code !== 6'd32 || bk !== 64'h0000_0001_FFFF_FFFF || {dll_lock, sat_hi, sat_lo} !== 3'b000) begin
      n_errors++; $display("FAIL async_reset: got code %0d bk %h flags %b want 32 00000001ffffffff 000",
                           dly_code, bk, {dll_lock, sat_hi, sat_lo});
    end
    @(posedge CLKIN);
    #1;
    RST = 1'b0;
    m_reset();
  endtask

  task automatic test_sat_hi();
    restart();
    for (int it = 0; it < 80 && m_code != 62; it++) votes(m_code < 62, 4);
    n_checks++;
    if (dly_code !== 6'd62) begin n_errors++; $display("FAIL sat_hi_setup: got %0d want 62", dly_code); end
    votes(1'b1, 4);
    n_checks++;
    if (dly_code !== 6'd63 || sat_hi !== 1'b0) begin
      n_errors++; $display("FAIL sat_hi_reach: got code %0d sat_hi %b want 63 0", dly_code, sat_hi);
    end
    votes(1'b1, 4);
    n_checks++;
    if (dly_code !== 6'd63 || sat_hi !== 1'b1 || bk !== {64{1'b1}}) begin
      n_errors++; $display("FAIL sat_hi_set: got code %0d sat_hi %b bk %h want 63 1 all-ones", dly_code, sat_hi, bk);
    end
    votes(1'b0, 4);
    n_checks++;
    if (dly_code !== 6'd62 || sat_hi !== 1'b0) begin
      n_errors++; $display("FAIL sat_hi_clear: got code %0d sat_hi %b want 62 0", dly_code, sat_hi);
    end
  endtask

  task automatic test_sat_lo();
    restart();
    for (int it = 0; it < 80 && m_code != 1; it++) votes(m_code < 1, 4);
    n_checks++;
    if (dly_code !== 6'd1) begin n_errors++; $display("FAIL sat_lo_setup: got %0d want 1", dly_code); end
    votes(1'b0, 4);
    n_checks++;
    if (dly_code !== 6'd0 || bk !== 64'h1 || sat_lo !== 1'b0) begin
      n_errors++; $display("FAIL sat_lo_reach: got code %0d bk %h sat_lo %b want 0 1 0", dly_code, bk, sat_lo);
    end
    votes(1'b0, 4);
    n_checks++;
    if (dly_code !== 6'd0 || bk !== 64'h1 || sat_lo !== 1'b1) begin
      n_errors++; $display("FAIL sat_lo_set: got code %0d bk %h sat_lo %b want 0 1 1", dly_code, bk, sat_lo);
    end
  endtask

  task automatic test_disable();
    int held;
    restart();
    votes(1'b1, 4); votes(1'b0, 4); votes(1'b1, 4); votes(1'b0, 4);
    n_checks++;
    if (dll_lock !== 1'b1) begin n_errors++; $display("FAIL dis_locked: got %b want 1", dll_lock); end
    held = m_code;
    votes(1'b1, 2);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (dll_lock !== 1'b0 || dly_code !== 6'(held)) begin
      n_errors++; $display("FAIL dis_edge: got lock %b code %0d want 0 %0d", dll_lock, dly_code, held);
    end
    repeat (8) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (dly_code !== 6'(held)) begin n_errors++; $display("FAIL dis_votes: got %0d want %0d", dly_code, held); end
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    votes(1'b1, 3);
    n_checks++;
    if (dly_code !== 6'(held)) begin n_errors++; $display("FAIL dis_acc_cleared: got %0d want %0d", dly_code, held); end
    votes(1'b1, 1);
    n_checks++;
    if (dly_code !== 6'(held + 1)) begin n_errors++; $display("FAIL dis_resume: got %0d want %0d", dly_code, held + 1); end
  endtask

  task automatic test_override();
    int prev, expc;
    restart();
    prev = m_code;
    ovrd_en = 1'b1; ovrd_code = 6'd5;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    expc = OVRD_ON ? 5 : prev;
    n_checks++;
    if (dly_code !== 6'(expc) || bk !== therm_ref(expc)) begin
      n_errors++; $display("FAIL ovrd_load: got code %0d bk %h want %0d %h", dly_code, bk, expc, therm_ref(expc));
    end
    votes(1'b1, 8);
    expc = OVRD_ON ? 5 : prev + 2;
    n_checks++;
    if (dly_code !== 6'(expc)) begin n_errors++; $display("FAIL ovrd_votes: got %0d want %0d", dly_code, expc); end
    ovrd_en = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    votes(1'b1, 4);
    n_checks++;
    if (dly_code !== 6'(expc + 1)) begin n_errors++; $display("FAIL ovrd_resume: got %0d want %0d", dly_code, expc + 1); end
  endtask

  task automatic test_random();
    int bias_tab[8] = '{90, 10, 55, 97, 3, 50, 90, 45};
    logic [72:0] act, expv;
    bit en, v, up, dn;
    restart();
    for (int c = 0; c < 2400; c++) begin
      int bias;
      bias      = bias_tab[c / 300];
      en        = ($urandom_range(0, 31) != 0);
      v         = ($urandom_range(0, 7) != 0);
      up        = (int'($urandom_range(0, 99)) < bias);
      dn        = (int'($urandom_range(0, 99)) < 100 - bias);
      ovrd_en   = ($urandom_range(0, 99) == 0);
      ovrd_code = 6'($urandom_range(0, 63));
      cyc(en, v, up, dn);
      act  = {dly_code, dll_lock, sat_hi, sat_lo, bk};
      expv = {6'(m_code), m_mode == M_LOCKED, m_shi, m_slo, therm_ref(m_code)};
      n_checks++;
      if (act !== expv) begin
        n_errors++; $display("FAIL random_c%0d: got code/lock/hi/lo/bk %h want %h", c, act, expv);
      end
    end
    ovrd_en = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete within time budget");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_step();
    test_lock();
    test_async_reset();
    test_sat_hi();
    test_sat_lo();
    test_disable();
    test_override();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
